bus_timer_responder: RTL and testbench

- Memory-mapped responder on the core's data bus (addr/be/wen/wdata/rdata), sitting alongside the byte-lane data RAM.
- Decodes word accesses to a small register file containing a prescaled 32-bit timer, a compare register, a sticky match flag with interrupt, and a 32-bit display register for the seven-segment driver.
- Read timing matches the synchronous RAM (1-cycle read latency), so the core sees both targets identically.

---
 rtl/bus_timer_responder.sv | 213 +++++++++++++++++++++
 tb/tb_bus_timer_responder.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_timer_responder.sv
// ---------------------------------------------------------------------------
// bus_timer_responder
//
// Memory-mapped timer/display responder on the core data bus. It answers
// word accesses with the same 1-cycle read latency as the synchronous data
// RAM, so the core treats both targets identically.
//
// Register map (addr[4:2]):
//   0 CTRL    [0] en, [1] auto_reload, [2] irq_en
//   1 PRESC   [PRESC_W-1:0] prescaler reload value
//   2 COUNT   32-bit timer value
//   3 CMP     32-bit compare value
//   4 STATUS  [0] match (write 1 to clear)
//   5 DISP    32-bit display value, driven out on disp
//   6,7       read as 0, writes ignored
//
// Ports:
//   clk    system clock, all state on the rising edge
//   rst    asynchronous active-high reset
//   sel    block selected (base address decoded upstream)
//   addr   byte address; addr[4:2] picks the word
//   be     byte enables, be[i] covers bits 8i+7:8i
//   wen    1 = write, 0 = read (qualified by sel)
//   wdata  write data
//   rdata  registered read data (held between reads)
//   irq    STATUS.match & CTRL.irq_en
//   disp   DISP register contents, to the seven-segment driver
// ---------------------------------------------------------------------------
module bus_timer_responder #(
    parameter int unsigned PRESC_W  = 16,
    parameter logic [31:0] DISP_RST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sel,
    input  logic [7:0]  addr,
    input  logic [3:0]  be,
    input  logic        wen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq,
    output logic [31:0] disp
);

    typedef enum logic [2:0] {
        REG_CTRL   = 3'd0,
        REG_PRESC  = 3'd1,
        REG_COUNT  = 3'd2,
        REG_CMP    = 3'd3,
        REG_STATUS = 3'd4,
        REG_DISP   = 3'd5,
        REG_RSVD6  = 3'd6,
        REG_RSVD7  = 3'd7
    } reg_sel_e;

    localparam logic [PRESC_W-1:0] PCNT_ONE = PRESC_W'(1);

    // Architectural state
    logic [2:0]         ctrl;
    logic [PRESC_W-1:0] presc;
    logic [PRESC_W-1:0] pcnt;
    logic [31:0]        count;
    logic [31:0]        cmp;
    logic               match;

    // Bus decode
    reg_sel_e    word;
    logic        wr_req;
    logic        rd_req;
    logic [31:0] lane_mask;

    logic wr_ctrl;
    logic wr_presc;
    logic wr_count;
    logic wr_cmp;
    logic wr_status;
    logic wr_disp;

    // Timer datapath
    logic        en;
    logic        auto_reload;
    logic        irq_en;
    logic        tick;
    logic        hit;
    logic        clear_match;
    logic [31:0] count_tick;
    logic [31:0] count_next;
    logic [31:0] rd_word;

    // Byte offset and upper address bits are decoded elsewhere.
    logic unused_addr;
    assign unused_addr = ^{addr[7:5], addr[1:0]};

    assign word   = reg_sel_e'(addr[4:2]);
    // A write with no byte enabled is a no-op everywhere, including the
    // prescaler clear on a PRESC write.
    assign wr_req = sel & wen & (|be);
    assign rd_req = sel & ~wen;

    assign lane_mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};

    assign wr_ctrl   = wr_req && (word == REG_CTRL);
    assign wr_presc  = wr_req && (word == REG_PRESC);
    assign wr_count  = wr_req && (word == REG_COUNT);
    assign wr_cmp    = wr_req && (word == REG_CMP);
    assign wr_status = wr_req && (word == REG_STATUS);
    assign wr_disp   = wr_req && (word == REG_DISP);

    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_val,
        input logic [31:0] new_val,
        input logic [31:0] mask
    );
        return (old_val & ~mask) | (new_val & mask);
    endfunction

    assign en          = ctrl[0];
    assign auto_reload = ctrl[1];
    assign irq_en      = ctrl[2];

    // The tick and the compare both look at pre-edge register values, so a
    // CMP or PRESC write landing on a tick only takes effect afterwards.
    assign tick        = en && (pcnt == presc);
    assign hit         = tick && (count == cmp);
    assign clear_match = wr_status && be[0] && wdata[0];

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        count_tick = count;
        if (tick) begin
            if (hit && auto_reload) begin
                count_tick = 32'd0;
            end else begin
                count_tick = count + 32'd1;
            end
        end
    end

    // Written bytes override the tick result; unwritten bytes keep it.
    assign count_next = wr_count ? merge_bytes(count_tick, wdata, lane_mask)
                                 : count_tick;

    always_comb begin
        rd_word = 32'd0;
        case (word)
            REG_CTRL:   rd_word = {29'd0, ctrl};
            REG_PRESC:  rd_word = 32'(presc);
            REG_COUNT:  rd_word = count;
            REG_CMP:    rd_word = cmp;
            REG_STATUS: rd_word = {31'd0, match};
            REG_DISP:   rd_word = disp;
            default:    rd_word = 32'd0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl  <= 3'd0;
            presc <= '0;
            pcnt  <= '0;
            count <= 32'd0;
            cmp   <= 32'hFFFF_FFFF;
            match <= 1'b0;
            disp  <= DISP_RST;
            rdata <= 32'd0;
        end else begin
            // Prescaler: held at 0 while disabled, cleared by a PRESC write,
            // otherwise counts 0..PRESC and wraps on the tick.
            if (!en || wr_presc || tick) begin
                pcnt <= '0;
            end else begin
                pcnt <= pcnt + PCNT_ONE;
            end

            count <= count_next;

            // A match set in the same cycle as a W1C wins.
            if (hit) begin
                match <= 1'b1;
            end else if (clear_match) begin
                match <= 1'b0;
            end

            if (wr_ctrl && be[0]) begin
                ctrl <= wdata[2:0];
            end

            if (wr_presc) begin
                presc <= (presc & ~lane_mask[PRESC_W-1:0])
                       | (wdata[PRESC_W-1:0] & lane_mask[PRESC_W-1:0]);
            end

            if (wr_cmp) begin
                cmp <= merge_bytes(cmp, wdata, lane_mask);
            end

            if (wr_disp) begin
                disp <= merge_bytes(disp, wdata, lane_mask);
            end

            if (rd_req) begin
                rdata <= rd_word & lane_mask;
            end
        end
    end

    // Combinational from registers so it follows reset with no clock edge.
    assign irq = match & irq_en;

endmodule

// File: tb/tb_bus_timer_responder.sv
// ---------------------------------------------------------------------------
// tb_bus_timer_responder
//
// Directed scenarios followed by randomized bus traffic, all checked against
// a behavioural model of the register file kept in this bench.
// ---------------------------------------------------------------------------
module tb_bus_timer_responder;

    localparam int          PW = 16;
    localparam logic [31:0] DR = 32'h5A5A_0F0F;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic [7:0]  addr;
    logic [3:0]  be;
    logic        wen;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;
    logic [31:0] disp;

    bus_timer_responder #(
        .PRESC_W  (PW),
        .DISP_RST (DR)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .sel   (sel),
        .addr  (addr),
        .be    (be),
        .wen   (wen),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq),
        .disp  (disp)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s got=%08h exp=%08h at %0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [2:0]    m_ctrl;
    logic [PW-1:0] m_presc;
    int unsigned   m_pcnt;
    logic [31:0]   m_count;
    logic [31:0]   m_cmp;
    logic          m_match;
    logic [31:0]   m_disp;
    logic [31:0]   m_rdata;

    task automatic model_reset();
        m_ctrl  = 3'd0;
        m_presc = '0;
        m_pcnt  = 0;
        m_count = 32'd0;
        m_cmp   = 32'hFFFF_FFFF;
        m_match = 1'b0;
        m_disp  = DR;
        m_rdata = 32'd0;
    endtask

    function automatic logic [31:0] put_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0] b);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++)
            if (b[i]) r[8*i +: 8] = new_v[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] keep_bytes(input logic [31:0] v, input logic [3:0] b);
        logic [31:0] r;
        r = v;
        for (int i = 0; i < 4; i++)
            if (!b[i]) r[8*i +: 8] = 8'h00;
        return r;
    endfunction

    // True when the coming edge produces a timer tick with COUNT==CMP.
    function automatic bit model_hit_next();
        return m_ctrl[0] && (m_pcnt == int'(m_presc)) && (m_count == m_cmp);
    endfunction

    // Applies one clock edge of bus activity to the model.
    task automatic model_step(input logic s, input logic w, input logic [7:0] a,
                              input logic [3:0] b, input logic [31:0] d);
        int          wd;
        bit          wr, rd, tick, hit;
        logic [31:0] nxt_count, v, tmp;
        wd   = int'(a[4:2]);
        wr   = s && w && (b != 4'h0);
        rd   = s && !w;
        tick = m_ctrl[0] && (m_pcnt == int'(m_presc));
        hit  = tick && (m_count == m_cmp);

        if (rd) begin
            case (wd)
                0:       v = {29'd0, m_ctrl};
                1:       v = 32'(m_presc);
                2:       v = m_count;
                3:       v = m_cmp;
                4:       v = {31'd0, m_match};
                5:       v = m_disp;
                default: v = 32'd0;
            endcase
            m_rdata = keep_bytes(v, b);
        end

        nxt_count = m_count;
        if (tick) nxt_count = (hit && m_ctrl[1]) ? 32'd0 : m_count + 32'd1;

        if (!m_ctrl[0] || (wr && wd == 1) || tick) m_pcnt = 0;
        else m_pcnt = m_pcnt + 1;

        if (hit) m_match = 1'b1;
        else if (wr && wd == 4 && b[0] && d[0]) m_match = 1'b0;

        if (wr) begin
            case (wd)
                0: if (b[0]) m_ctrl = d[2:0];
                1: begin
                    tmp = put_bytes(32'(m_presc), d, b);
                    m_presc = tmp[PW-1:0];
                end
                2: nxt_count = put_bytes(nxt_count, d, b);
                3: m_cmp = put_bytes(m_cmp, d, b);
                5: m_disp = put_bytes(m_disp, d, b);
                default: ;
            endcase
        end
        m_count = nxt_count;
    endtask

    // ---------------- bus driver ----------------
    task automatic do_cycle(input logic s, input logic w, input logic [7:0] a,
                            input logic [3:0] b, input logic [31:0] d);
        sel = s; wen = w; addr = a; be = b; wdata = d;
        @(posedge clk);
        model_step(s, w, a, b, d);
        #1;
        check("rdata", rdata, m_rdata);
        check("irq", {31'd0, irq}, {31'd0, m_ctrl[2] & m_match});
        check("disp", disp, m_disp);
    endtask

    task automatic wr_reg(input int wd, input logic [31:0] d, input logic [3:0] b);
        do_cycle(1'b1, 1'b1, 8'(wd << 2), b, d);
    endtask

    task automatic rd_reg(input int wd, input logic [3:0] b);
        do_cycle(1'b1, 1'b0, 8'(wd << 2), b, 32'd0);
    endtask

    task automatic idle();
        do_cycle(1'b0, 1'b0, 8'd0, 4'h0, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] rst_exp [8];
    bit          found;

    initial begin
        rst_exp = '{32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0, DR, 32'd0, 32'd0};
        rst = 1'b1; sel = 1'b0; wen = 1'b0; addr = 8'd0; be = 4'h0; wdata = 32'd0;
        #12;
        model_reset();
        check("rst_rdata", rdata, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_disp", disp, DR);
        rst = 1'b0;

        // 1. reset readback
        for (int i = 0; i < 8; i++) begin
            rd_reg(i, 4'hF);
            check("rst_read", rdata, rst_exp[i]);
        end

        // 2. byte enables
        wr_reg(5, 32'hAABB_CCDD, 4'hF);
        check("disp_full", disp, 32'hAABB_CCDD);
        wr_reg(5, 32'h1122_3344, 4'b0101);
        check("disp_part", disp, 32'hAA22_CC44);
        rd_reg(5, 4'hF);
        check("rd_be_f", rdata, 32'hAA22_CC44);
        rd_reg(5, 4'b0011);
        check("rd_be_3", rdata, 32'h0000_CC44);
        wr_reg(6, 32'hFFFF_FFFF, 4'hF);
        rd_reg(6, 4'hF);
        check("rsvd_rd", rdata, 32'd0);

        // 3. prescale / count
        wr_reg(1, 32'd3, 4'hF);
        wr_reg(2, 32'd0, 4'hF);
        wr_reg(0, 32'd1, 4'hF);
        for (int i = 0; i < 24; i++) rd_reg(2, 4'hF);
        wr_reg(0, 32'd0, 4'hF);
        for (int i = 0; i < 4; i++) rd_reg(2, 4'hF);

        // 4. match / auto-reload / irq
        wr_reg(4, 32'd1, 4'hF);
        wr_reg(1, 32'd0, 4'hF);
        wr_reg(2, 32'd0, 4'hF);
        wr_reg(3, 32'd2, 4'hF);
        wr_reg(0, 32'd7, 4'hF);
        for (int i = 0; i < 9; i++) rd_reg(2, 4'hF);
        check("irq_set", {31'd0, irq}, 32'd1);
        found = 0;
        for (int i = 0; i < 8 && !found; i++) begin
            if (!model_hit_next()) found = 1;
            else rd_reg(2, 4'hF);
        end
        check("nomatch_wait", 32'(found), 32'd1);
        wr_reg(4, 32'd1, 4'h1);
        check("irq_clr", {31'd0, irq}, 32'd0);
        found = 0;
        for (int i = 0; i < 8 && !found; i++) begin
            if (model_hit_next()) found = 1;
            else rd_reg(2, 4'hF);
        end
        check("match_wait", 32'(found), 32'd1);
        wr_reg(4, 32'd1, 4'h1);
        rd_reg(4, 4'hF);
        check("w1c_collide", rdata, 32'd1);

        // 5. wrap and write collision
        wr_reg(0, 32'd0, 4'hF);
        wr_reg(4, 32'd1, 4'hF);
        wr_reg(2, 32'hFFFF_FFFE, 4'hF);
        wr_reg(3, 32'd5, 4'hF);
        wr_reg(1, 32'd0, 4'hF);
        wr_reg(0, 32'd1, 4'hF);
        for (int i = 0; i < 4; i++) rd_reg(2, 4'hF);
        wr_reg(2, 32'd100, 4'hF);
        rd_reg(2, 4'hF);
        check("coll_100", rdata, 32'd100);
        rd_reg(2, 4'hF);
        check("coll_101", rdata, 32'd101);
        rd_reg(4, 4'hF);
        check("wrap_nomatch", rdata, 32'd0);

        // 6. async reset mid-run with irq asserted
        wr_reg(0, 32'd0, 4'hF);
        wr_reg(2, 32'd0, 4'hF);
        wr_reg(3, 32'd3, 4'hF);
        wr_reg(0, 32'd7, 4'hF);
        for (int i = 0; i < 6; i++) idle();
        rd_reg(5, 4'hF);
        check("pre_rst_irq", {31'd0, irq}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_irq", {31'd0, irq}, 32'd0);
        check("async_rdata", rdata, 32'd0);
        check("async_disp", disp, DR);
        model_reset();
        #1 rst = 1'b0;
        rd_reg(2, 4'hF);
        check("async_count", rdata, 32'd0);

        // randomized traffic
        wr_reg(1, 32'd1, 4'hF);
        wr_reg(3, 32'd6, 4'hF);
        wr_reg(0, 32'd7, 4'hF);
        for (int n = 0; n < 3000; n++) begin
            logic        s, w;
            logic [7:0]  a;
            logic [3:0]  b;
            logic [31:0] d;
            s = ($urandom_range(0, 9) != 0);
            w = ($urandom_range(0, 3) == 0);
            a = 8'($urandom);
            b = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
            d = $urandom;
            case (a[4:2])
                3'd0: if ($urandom_range(0, 3) != 0) d[0] = 1'b1;
                3'd1: d = d & 32'h3;
                3'd2, 3'd3: if ($urandom_range(0, 1) == 0) d = d & 32'hF;
                default: ;
            endcase
            do_cycle(s, w, a, b, d);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
